// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch PC generator with a DEPTH-entry prefetch queue.
// Defining FETCH_QUEUE_BYPASS_EN forwards a returning word straight to decode when the queue is empty.
module fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic [31:0]                o_addr_i,
  output logic                       o_rd_i,
  input  logic                       i_valid_i,
  input  logic [31:0]                i_data_in_i,
  input  logic                       i_branch_en,
  input  logic [31:0]                i_branch_addr,
  input  logic                       i_inst_ready,
  output logic                       o_inst_valid,
  output logic [31:0]                o_inst,
  output logic [31:0]                o_pc,
  output logic [31:0]                o_ret,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic        push, pop, pop_stored, store, byp, stored_valid;
  logic [31:0] head_inst, head_pc;

  assign stored_valid = (count_q != '0);
  assign o_rd_i       = !i_rst && !i_branch_en && (count_q != FULL);
  assign push         = o_rd_i && i_valid_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = push && !stored_valid;
`else
  assign byp = 1'b0;
`endif

  assign o_inst_valid = stored_valid || byp;
  assign pop          = o_inst_valid && i_inst_ready;
  assign pop_stored   = pop && stored_valid;
  // A bypassed word that decode takes immediately never lands in storage.
  assign store        = push && !(byp && i_inst_ready);

  always_comb begin
    head_inst = 32'h0;
    head_pc   = 32'h0;
    if (stored_valid) begin
      head_inst = inst_mem_q[head_q];
      head_pc   = pc_mem_q[head_q];
    end else if (byp) begin
      head_inst = i_data_in_i;
      head_pc   = pc_q;
    end
  end

  assign o_inst   = head_inst;
  assign o_pc     = head_pc;
  assign o_ret    = o_inst_valid ? head_pc + 32'd4 : 32'h0;
  assign o_addr_i = pc_q;
  assign o_count  = count_q;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_branch_en) begin
      pc_d    = i_branch_addr;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push)       pc_d   = pc_q + 32'd4;
      if (store)      tail_d = tail_q + 1'b1;
      if (pop_stored) head_d = head_q + 1'b1;
      count_d = count_q + CW'(store) - CW'(pop_stored);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q    <= RESET_ADDR;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (store) begin
      inst_mem_q[tail_q] <= i_data_in_i;
      pc_mem_q[tail_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized check of fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, valid, br, ready;
  logic [31:0] data, baddr;
  logic [31:0] addr, inst, pc, ret;
  logic        rd, ivalid;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mq[$];
  logic [31:0] mpc;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
    .i_clk(clk), .i_rst(rst), .o_addr_i(addr), .o_rd_i(rd),
    .i_valid_i(valid), .i_data_in_i(data), .i_branch_en(br),
    .i_branch_addr(baddr), .i_inst_ready(ready), .o_inst_valid(ivalid),
    .o_inst(inst), .o_pc(pc), .o_ret(ret), .o_count(count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, compare against the model, then advance the model at the edge.
  task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                       input logic b, input logic [31:0] ba, input logic rdy);
    logic        e_rd, e_push, e_byp, e_valid;
    logic [31:0] e_inst, e_pc;
    rst = r; valid = v; data = d; br = b; baddr = ba; ready = rdy;
    #1;
    e_rd   = !r && !b && (mq.size() != DEPTH);
    e_push = e_rd && v;
`ifdef FETCH_QUEUE_BYPASS_EN
    e_byp  = e_push && (mq.size() == 0);
`else
    e_byp  = 1'b0;
`endif
    e_valid = (mq.size() > 0) || e_byp;
    e_inst  = (mq.size() > 0) ? mq[0][63:32] : (e_byp ? d : 32'h0);
    e_pc    = (mq.size() > 0) ? mq[0][31:0]  : (e_byp ? mpc : 32'h0);
    check_eq("addr",  addr, mpc);
    check_eq("rd",    32'(rd), 32'(e_rd));
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("valid", 32'(ivalid), 32'(e_valid));
    check_eq("inst",  inst, e_inst);
    check_eq("pc",    pc, e_pc);
    check_eq("ret",   ret, e_valid ? e_pc + 32'd4 : 32'h0);
    @(posedge clk);
    if (r) begin
      mq.delete();
      mpc = 32'h0;
    end else if (b) begin
      mq.delete();
      mpc = ba;
    end else begin
      if (e_valid && rdy && mq.size() > 0) void'(mq.pop_front());
      if (e_push) begin
        if (!(e_byp && rdy)) mq.push_back({d, mpc});
        mpc = mpc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int pushes;
    rst = 1'b1; valid = 1'b0; data = '0; br = 1'b0; baddr = '0; ready = 1'b0;
    mpc = 32'h0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'hdead, 0, 0, 1);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_valid", 32'(ivalid), 32'd0);
    check_eq("rst_addr0", addr, 32'h0);

    // reset release then fill with decode stalled
    cycle(0, 1, 32'h1000, 0, 0, 0);
    check_eq("addr1", addr, 32'h4);
`ifndef FETCH_QUEUE_BYPASS_EN
    check_eq("lat1_valid", 32'(ivalid), 32'd1);
`endif
    cycle(0, 1, 32'h1001, 0, 0, 0);
    check_eq("addr2", addr, 32'h8);
    cycle(0, 1, 32'h1002, 0, 0, 0);
    cycle(0, 1, 32'h1003, 0, 0, 0);
    check_eq("full_count", 32'(count), 32'd4);
    cycle(0, 1, 32'h1004, 0, 0, 0);
    check_eq("full_addr", addr, 32'h10);
    check_eq("full_rd", 32'(rd), 32'd0);
    check_eq("full_pc", pc, 32'h0);
    check_eq("full_ret", ret, 32'h4);
    check_eq("full_inst", inst, 32'h1000);

    // redirect on a full queue with a push attempt and pop request
    cycle(0, 1, 32'h2000, 1, 32'h100, 1);
    check_eq("br_count", 32'(count), 32'd0);
    check_eq("br_addr", addr, 32'h100);
    check_eq("br_valid", 32'(ivalid), 32'd0);
    cycle(0, 1, 32'h3000, 0, 0, 0);
    check_eq("br_head_pc", pc, 32'h100);

    // steady stream
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 32'h4000 + i, 0, 0, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
      check_eq("stream_count", 32'(count), 32'd0);
`else
      check_eq("stream_count", 32'(count), 32'd1);
`endif
    end

    // alternating valid with random ready until 3*DEPTH pushes
    pushes = 0;
    for (int i = 0; i < 200 && pushes < 3 * DEPTH; i++) begin
      logic v;
      v = (i % 2 == 0);
      if (v && mq.size() != DEPTH) pushes++;
      cycle(0, v, $urandom, 0, 0, 1'($urandom_range(0, 1)));
    end
    check_eq("wrap_pushes", 32'(pushes), 32'(3 * DEPTH));
    while (mq.size() > 0 && n_cmp < 100000) cycle(0, 0, 0, 0, 0, 1);

    // fully random traffic with occasional redirects and resets
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), $urandom,
            $urandom_range(0, 19) == 0, $urandom & 32'hffff_fffc,
            1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
